// File: rtl/fwd_net.sv
// fwd_net: operand-forwarding network with a per-lane result history of DEPTH stages.
// Optional hit/miss statistics are built when the macro FWD_HIT_CNT_EN is defined.
module fwd_net #(
    parameter int NUM_LANES = 2,
    parameter int NUM_SRC   = 4,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 6,
    parameter int DEPTH     = 3,
    parameter int ZERO_TAG  = 1,
    localparam int SW       = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_LANES-1:0]       res_vld,
    input  logic [NUM_LANES*TAG_W-1:0] res_tag,
    input  logic [NUM_LANES*XLEN-1:0]  res_data,
    input  logic [NUM_SRC-1:0]         src_vld,
    input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
    input  logic [NUM_SRC*XLEN-1:0]    rf_data,
    output logic [NUM_SRC*XLEN-1:0]    op_data,
    output logic [NUM_SRC-1:0]         op_hit,
    output logic [NUM_SRC*SW-1:0]      op_stage,
    output logic                       dup_tag_err
`ifdef FWD_HIT_CNT_EN
    ,
    output logic [DEPTH*32-1:0]        hit_cnt,
    output logic [31:0]                miss_cnt
`endif
);

    logic             live_vld_s [NUM_LANES];
    logic             stg_vld_s  [DEPTH][NUM_LANES];
    logic [TAG_W-1:0] stg_tag_s  [DEPTH][NUM_LANES];
    logic [XLEN-1:0]  stg_data_s [DEPTH][NUM_LANES];
    logic             sel_hit_s;
    logic [XLEN-1:0]  sel_data_s;
    logic [SW-1:0]    sel_stage_s;
    logic             match_s;
    logic [TAG_W-1:0] tag_s;
    logic             dup_s;
    logic             dup_tag_err_r;

    // Live-bus qualification: an x0 result is neither forwarded nor captured.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            live_vld_s[l] = res_vld[l] &&
                !((ZERO_TAG != 0) && (res_tag[l*TAG_W +: TAG_W] == {TAG_W{1'b0}}));
        end
    end

    generate
        if (DEPTH > 1) begin : g_hist
            logic             hist_vld_r  [1:DEPTH-1][NUM_LANES];
            logic [TAG_W-1:0] hist_tag_r  [1:DEPTH-1][NUM_LANES];
            logic [XLEN-1:0]  hist_data_r [1:DEPTH-1][NUM_LANES];

            // Unconditional history shift; reset and flush only drop the valid bits.
            always_ff @(posedge clk) begin
                for (int s = 1; s < DEPTH; s++) begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        if (rst || flush) begin
                            hist_vld_r[s][l] <= 1'b0;
                        end else begin
                            hist_vld_r[s][l] <= stg_vld_s[s-1][l];
                        end
                        hist_tag_r[s][l]  <= stg_tag_s[s-1][l];
                        hist_data_r[s][l] <= stg_data_s[s-1][l];
                    end
                end
            end

            // Candidate view: stage 0 is the live bus, older stages come from history.
            always_comb begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    stg_vld_s[0][l]  = live_vld_s[l];
                    stg_tag_s[0][l]  = res_tag[l*TAG_W +: TAG_W];
                    stg_data_s[0][l] = res_data[l*XLEN +: XLEN];
                    for (int s = 1; s < DEPTH; s++) begin
                        stg_vld_s[s][l]  = hist_vld_r[s][l];
                        stg_tag_s[s][l]  = hist_tag_r[s][l];
                        stg_data_s[s][l] = hist_data_r[s][l];
                    end
                end
            end
        end else begin : g_nohist
            // Candidate view with only the live stage-0 bypass.
            always_comb begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    stg_vld_s[0][l]  = live_vld_s[l];
                    stg_tag_s[0][l]  = res_tag[l*TAG_W +: TAG_W];
                    stg_data_s[0][l] = res_data[l*XLEN +: XLEN];
                end
            end
        end
    endgenerate

    // Operand select: scanning oldest-to-youngest so the youngest, lowest-lane match is left standing.
    always_comb begin
        sel_hit_s   = 1'b0;
        sel_data_s  = {XLEN{1'b0}};
        sel_stage_s = {SW{1'b0}};
        match_s     = 1'b0;
        tag_s       = {TAG_W{1'b0}};
        for (int p = 0; p < NUM_SRC; p++) begin
            tag_s       = src_tag[p*TAG_W +: TAG_W];
            sel_hit_s   = 1'b0;
            sel_data_s  = {XLEN{1'b0}};
            sel_stage_s = {SW{1'b0}};
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int l = NUM_LANES - 1; l >= 0; l--) begin
                    match_s     = stg_vld_s[s][l] && (stg_tag_s[s][l] == tag_s);
                    sel_hit_s   = match_s ? 1'b1 : sel_hit_s;
                    sel_data_s  = match_s ? stg_data_s[s][l] : sel_data_s;
                    sel_stage_s = match_s ? SW'(s + 1) : sel_stage_s;
                end
            end
            if (!src_vld[p]) begin
                op_data[p*XLEN +: XLEN] = rf_data[p*XLEN +: XLEN];
                op_hit[p]               = 1'b0;
                op_stage[p*SW +: SW]    = {SW{1'b0}};
            end else if ((ZERO_TAG != 0) && (tag_s == {TAG_W{1'b0}})) begin
                op_data[p*XLEN +: XLEN] = {XLEN{1'b0}};
                op_hit[p]               = 1'b0;
                op_stage[p*SW +: SW]    = {SW{1'b0}};
            end else if (sel_hit_s) begin
                op_data[p*XLEN +: XLEN] = sel_data_s;
                op_hit[p]               = 1'b1;
                op_stage[p*SW +: SW]    = sel_stage_s;
            end else begin
                op_data[p*XLEN +: XLEN] = rf_data[p*XLEN +: XLEN];
                op_hit[p]               = 1'b0;
                op_stage[p*SW +: SW]    = {SW{1'b0}};
            end
        end
    end

    // Duplicate-tag detect across every lane pair on the live bus.
    always_comb begin
        dup_s = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = i + 1; j < NUM_LANES; j++) begin
                dup_s = dup_s | (res_vld[i] & res_vld[j] &
                        (res_tag[i*TAG_W +: TAG_W] == res_tag[j*TAG_W +: TAG_W]) &
                        (res_tag[i*TAG_W +: TAG_W] != {TAG_W{1'b0}}));
            end
        end
    end

    // Sticky duplicate-tag error flag.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            dup_tag_err_r <= 1'b0;
        end else if (dup_s) begin
            dup_tag_err_r <= 1'b1;
        end else begin
            dup_tag_err_r <= dup_tag_err_r;
        end
    end

    assign dup_tag_err = dup_tag_err_r;

`ifdef FWD_HIT_CNT_EN
    logic [DEPTH-1:0][31:0] hit_cnt_r;
    logic [31:0]            miss_cnt_r;
    logic [31:0]            hit_inc_s [DEPTH];
    logic [31:0]            miss_inc_s;
    logic                   counted_s;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Per-cycle increments summed over all lookup ports with a non-zero tag.
    always_comb begin
        miss_inc_s = 32'd0;
        counted_s  = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            hit_inc_s[s] = 32'd0;
        end
        for (int p = 0; p < NUM_SRC; p++) begin
            counted_s  = src_vld[p] && (src_tag[p*TAG_W +: TAG_W] != {TAG_W{1'b0}});
            miss_inc_s = miss_inc_s + ((counted_s && !op_hit[p]) ? 32'd1 : 32'd0);
            for (int s = 0; s < DEPTH; s++) begin
                hit_inc_s[s] = hit_inc_s[s] +
                    ((counted_s && op_hit[p] && (op_stage[p*SW +: SW] == SW'(s + 1))) ? 32'd1 : 32'd0);
            end
        end
    end

    // Saturating statistics counters; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_r  <= {(DEPTH*32){1'b0}};
            miss_cnt_r <= 32'd0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                hit_cnt_r[s] <= sat_add(hit_cnt_r[s], hit_inc_s[s]);
            end
            miss_cnt_r <= sat_add(miss_cnt_r, miss_inc_s);
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_fwd_net.sv
// Directed bench for fwd_net (default parameters); counter checks build with FWD_HIT_CNT_EN.
module tb_fwd_net;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [1:0]   res_vld;
    logic [11:0]  res_tag;
    logic [63:0]  res_data;
    logic [3:0]   src_vld;
    logic [23:0]  src_tag;
    logic [127:0] rf_data;
    logic [127:0] op_data;
    logic [3:0]   op_hit;
    logic [7:0]   op_stage;
    logic         dup_tag_err;
`ifdef FWD_HIT_CNT_EN
    logic [95:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fwd_net dut (
        .clk(clk), .rst(rst), .flush(flush),
        .res_vld(res_vld), .res_tag(res_tag), .res_data(res_data),
        .src_vld(src_vld), .src_tag(src_tag), .rf_data(rf_data),
        .op_data(op_data), .op_hit(op_hit), .op_stage(op_stage),
        .dup_tag_err(dup_tag_err)
`ifdef FWD_HIT_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [1:0]  rv;
        logic [5:0]  t0;
        logic [31:0] d0;
        logic [5:0]  t1;
        logic [31:0] d1;
        logic        sv;
        logic [5:0]  st;
        logic [31:0] rf;
        logic [31:0] e_data;
        logic        e_hit;
        logic [1:0]  e_stage;
        logic        e_dup;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    function automatic vec_t v(input logic r, input logic f, input logic [1:0] rv,
                               input logic [5:0] t0, input logic [31:0] d0,
                               input logic [5:0] t1, input logic [31:0] d1,
                               input logic sv, input logic [5:0] st, input logic [31:0] rf,
                               input logic [31:0] ed, input logic eh, input logic [1:0] es,
                               input logic edup);
        vec_t x;
        x.rst = r; x.flush = f; x.rv = rv; x.t0 = t0; x.d0 = d0; x.t1 = t1; x.d1 = d1;
        x.sv = sv; x.st = st; x.rf = rf;
        x.e_data = ed; x.e_hit = eh; x.e_stage = es; x.e_dup = edup;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0;
        res_vld = 2'b00; res_tag = 12'd0; res_data = 64'd0;
        src_vld = 4'b0000; src_tag = 24'd0;
        rf_data = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'h0000_0000};
    endtask

    task automatic apply(input vec_t x);
        rst = x.rst; flush = x.flush;
        res_vld = x.rv; res_tag = {x.t1, x.t0}; res_data = {x.d1, x.d0};
        src_vld = {3'b000, x.sv}; src_tag = {18'd0, x.st};
        rf_data = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, x.rf};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rst  fl   rv     t0  d0            t1  d1     sv   st  rf             e_data         hit  stg   dup
        vt[0]  = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd12,32'h1234, 32'h1234,      1'b0,2'd0,1'b0);
        vt[1]  = v(1'b0,1'b0,2'b01, 6'd5, 32'hAAAA_0001,6'd0,32'h0,  1'b1,6'd5, 32'h1,    32'hAAAA_0001, 1'b1,2'd1,1'b0);
        vt[2]  = v(1'b0,1'b0,2'b01, 6'd7, 32'h11,      6'd0,32'h0,   1'b1,6'd5, 32'h2,    32'hAAAA_0001, 1'b1,2'd2,1'b0);
        vt[3]  = v(1'b0,1'b0,2'b01, 6'd7, 32'h22,      6'd0,32'h0,   1'b1,6'd7, 32'h3,    32'h22,        1'b1,2'd1,1'b0);
        vt[4]  = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd7, 32'h4,    32'h22,        1'b1,2'd2,1'b0);
        vt[5]  = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd7, 32'h5,    32'h22,        1'b1,2'd3,1'b0);
        vt[6]  = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd7, 32'h77,   32'h77,        1'b0,2'd0,1'b0);
        vt[7]  = v(1'b0,1'b0,2'b10, 6'd0, 32'h0,       6'd9,32'h900, 1'b1,6'd9, 32'h5,    32'h900,       1'b1,2'd1,1'b0);
        vt[8]  = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b0,6'd9, 32'h8,    32'h8,         1'b0,2'd0,1'b0);
        vt[9]  = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd9, 32'h9,    32'h900,       1'b1,2'd3,1'b0);
        vt[10] = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd9, 32'h99,   32'h99,        1'b0,2'd0,1'b0);
        vt[11] = v(1'b0,1'b0,2'b01, 6'd3, 32'h333,     6'd0,32'h0,   1'b1,6'd3, 32'hB,    32'h333,       1'b1,2'd1,1'b0);
        vt[12] = v(1'b0,1'b1,2'b10, 6'd0, 32'h0,       6'd3,32'h444, 1'b1,6'd3, 32'hC,    32'h444,       1'b1,2'd1,1'b0);
        vt[13] = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd3, 32'hD,    32'hD,         1'b0,2'd0,1'b0);
        vt[14] = v(1'b0,1'b0,2'b11, 6'd0, 32'hF0,      6'd0,32'hF1,  1'b1,6'd0, 32'hEE,   32'h0,         1'b0,2'd0,1'b0);
        vt[15] = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd0, 32'hEF,   32'h0,         1'b0,2'd0,1'b0);
        vt[16] = v(1'b0,1'b0,2'b11, 6'd4, 32'hA,       6'd4,32'hB,   1'b1,6'd4, 32'h1,    32'hA,         1'b1,2'd1,1'b0);
        vt[17] = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd4, 32'h2,    32'hA,         1'b1,2'd2,1'b1);
        vt[18] = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd12,32'h12,   32'h12,        1'b0,2'd0,1'b1);
        vt[19] = v(1'b0,1'b1,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd4, 32'h13,   32'h13,        1'b0,2'd0,1'b1);
        vt[20] = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b0,6'd0, 32'h14,   32'h14,        1'b0,2'd0,1'b0);
        vt[21] = v(1'b0,1'b0,2'b01, 6'd10,32'h1010,    6'd0,32'h0,   1'b1,6'd10,32'h4,    32'h1010,      1'b1,2'd1,1'b0);
        vt[22] = v(1'b1,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd10,32'h5,    32'h1010,      1'b1,2'd2,1'b0);
        vt[23] = v(1'b0,1'b0,2'b00, 6'd0, 32'h0,       6'd0,32'h0,   1'b1,6'd10,32'h6,    32'h6,         1'b0,2'd0,1'b0);

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vt[i]);
            #2;
            chk($sformatf("v%0d_data", i),  op_data[31:0],            vt[i].e_data);
            chk($sformatf("v%0d_hit", i),   {31'd0, op_hit[0]},       {31'd0, vt[i].e_hit});
            chk($sformatf("v%0d_stage", i), {30'd0, op_stage[1:0]},   {30'd0, vt[i].e_stage});
            chk($sformatf("v%0d_dup", i),   {31'd0, dup_tag_err},     {31'd0, vt[i].e_dup});
            chk($sformatf("v%0d_p3rf", i),  op_data[127:96],          32'hDEAD_0003);
        end

        // Other ports: a matching tag without src_vld must still read the register file.
        @(negedge clk);
        idle();
        res_vld = 2'b10; res_tag = {6'd20, 6'd0}; res_data = {32'h0000_BEEF, 32'h0};
        src_vld = 4'b1000; src_tag = {6'd20, 6'd20, 6'd0, 6'd0};
        #2;
        chk("p3_data", op_data[127:96], 32'h0000_BEEF);
        chk("p3_stage", {30'd0, op_stage[7:6]}, 32'd1);
        chk("p2_novld_data", op_data[95:64], 32'hDEAD_0002);
        chk("p2_novld_hit", {31'd0, op_hit[2]}, 32'd0);
        @(negedge clk);
        idle();
        src_vld = 4'b0010; src_tag = {6'd0, 6'd0, 6'd20, 6'd0};
        #2;
        chk("p1_data", op_data[63:32], 32'h0000_BEEF);
        chk("p1_stage", {30'd0, op_stage[3:2]}, 32'd2);

`ifdef FWD_HIT_CNT_EN
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        idle();
        #2;
        chk("cnt_rst_hit", hit_cnt[31:0], 32'd0);
        chk("cnt_rst_miss", miss_cnt, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            idle();
            src_vld = 4'b0001;
            if (k < 3) begin
                res_vld = 2'b01; res_tag = {6'd0, 6'd30}; res_data = {32'h0, 32'h3030};
                src_tag = {18'd0, 6'd30};
            end else begin
                src_tag = {18'd0, 6'd31};
            end
        end
        @(negedge clk);
        idle();
        #2;
        chk("cnt_hit0", hit_cnt[31:0], 32'd3);
        chk("cnt_miss", miss_cnt, 32'd2);
        force dut.hit_cnt_r = {3{32'hFFFF_FFFF}};
        #1;
        release dut.hit_cnt_r;
        res_vld = 2'b01; res_tag = {6'd0, 6'd30}; res_data = {32'h0, 32'h3030};
        src_vld = 4'b0001; src_tag = {18'd0, 6'd30};
        @(negedge clk);
        idle();
        #2;
        chk("cnt_sat", hit_cnt[31:0], 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
